// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store unit: operation encodings, load FSM
// states, the posted-store entry layout and the lane/format helpers.
package mips_lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'h0,
    OP_LBU = 4'h1,
    OP_LH  = 4'h2,
    OP_LHU = 4'h3,
    OP_LW  = 4'h4,
    OP_LWL = 4'h5,
    OP_LWR = 4'h6,
    OP_SB  = 4'h8,
    OP_SH  = 4'h9,
    OP_SW  = 4'hA
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LREQ,
    RESP
  } lsu_state_t;

  // Word address is 30 bits, so bus addresses up to 32 bits are supported.
  typedef struct packed {
    logic [29:0] word_addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wbuf_entry_t;

  function automatic logic is_store_op(lsu_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(lsu_op_t op, logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: bad = lane[0];
      OP_LW, OP_SW:         bad = (lane != 2'b00);
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

  // LWL/LWR merge the shifted memory word with the untouched bytes of rt.
  function automatic logic [31:0] format_load(lsu_op_t op, logic [31:0] w,
                                              logic [31:0] rt, logic [1:0] n);
    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    sh = {n, 3'b000};
    b  = 8'(w >> sh);
    h  = n[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      OP_LWL:  r = (w << {~n, 3'b000}) |
                   (rt & (32'hFFFFFFFF >> ({1'b0, n, 3'b000} + 6'd8)));
      OP_LWR:  r = (w >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mips_bus_lsu_if.sv
// Core request/response channel plus Avalon-MM master signals of the LSU.
// Request transfers on a rising edge with req_valid && req_ready; resp_valid is
// a one-cycle pulse with no back-pressure; a bus beat completes when
// waitrequest is low, and the master holds address/data/byteenable until then.
interface mips_bus_lsu_if #(
  parameter int ADDR_W = 32
) ();
  import mips_lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  lsu_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_rt;

  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_fault;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [31:0]       readdata;

  modport master (
    input  req_valid, req_op, req_addr, req_rt, waitrequest, readdata,
    output req_ready, resp_valid, resp_data, resp_fault,
           address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_op, req_addr, req_rt, waitrequest, readdata,
    input  req_ready, resp_valid, resp_data, resp_fault,
           address, read, write, writedata, byteenable
  );

endinterface

// File: rtl/mips_lsu_wbuf.sv
// Posted-store FIFO: power-of-two depth, free-running wrapping pointers and an
// occupancy counter that stays put on a simultaneous push and pop.
module mips_lsu_wbuf import mips_lsu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wbuf_entry_t              push_data,
  input  logic                     pop,
  output wbuf_entry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  wbuf_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_bus_lsu.sv
// MIPS load/store unit on Avalon-MM: stores are posted through a write buffer,
// loads drain that buffer first so they always observe earlier stores.
module mips_bus_lsu import mips_lsu_pkg::*; #(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  mips_bus_lsu_if.master                bus,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output lsu_state_t                    state_dbg
);

  lsu_state_t        state;
  lsu_op_t           ld_op;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_rt;
  logic              read_q;

  wbuf_entry_t push_entry;
  wbuf_entry_t head;
  logic        wb_full;
  logic        wb_empty;
  logic        push;
  logic        pop;
  logic        accept;
  logic        misaligned;
  logic        store_op;
  logic [1:0]  lane;

  assign lane          = bus.req_addr[1:0];
  assign misaligned    = is_misaligned(bus.req_op, lane);
  assign store_op      = is_store_op(bus.req_op);
  assign bus.req_ready = reset && (state == IDLE) && !wb_full;
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept && store_op && !misaligned;
  assign pop           = bus.write && !bus.waitrequest;
  assign bus.write     = !wb_empty;
  assign bus.read      = read_q;
  assign state_dbg     = state;

  always_comb begin
    push_entry.word_addr = 30'(bus.req_addr[ADDR_W-1:2]);
    push_entry.data      = '0;
    push_entry.be        = '0;
    case (bus.req_op)
      OP_SB: begin
        push_entry.data = {24'd0, bus.req_rt[7:0]} << {lane, 3'b000};
        push_entry.be   = 4'b0001 << lane;
      end
      OP_SH: begin
        push_entry.data = lane[1] ? {bus.req_rt[15:0], 16'd0} : {16'd0, bus.req_rt[15:0]};
        push_entry.be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      OP_SW: begin
        push_entry.data = bus.req_rt;
        push_entry.be   = 4'b1111;
      end
      default: ;
    endcase
  end

  // Read and write cannot overlap: a read is only raised once the buffer is empty.
  always_comb begin
    bus.address    = '0;
    bus.writedata  = '0;
    bus.byteenable = '0;
    if (!wb_empty) begin
      bus.address    = {head.word_addr[ADDR_W-3:0], 2'b00};
      bus.writedata  = head.data;
      bus.byteenable = head.be;
    end else if (read_q) begin
      bus.address    = {ld_addr[ADDR_W-1:2], 2'b00};
      bus.byteenable = 4'b1111;
    end
  end

  mips_lsu_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (wb_full),
    .empty     (wb_empty),
    .count     (wbuf_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      read_q         <= 1'b0;
      ld_op          <= OP_LB;
      ld_addr        <= '0;
      ld_rt          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_fault <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (misaligned) begin
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
            end else if (store_op) begin
              bus.resp_valid <= 1'b1;
            end else begin
              ld_op   <= bus.req_op;
              ld_addr <= bus.req_addr;
              ld_rt   <= bus.req_rt;
              if (wbuf_count == '0) begin
                state  <= LREQ;
                read_q <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (wbuf_count == '0) begin
            state  <= LREQ;
            read_q <= 1'b1;
          end
        end
        LREQ: begin
          if (!bus.waitrequest) begin
            read_q         <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_data  <= format_load(ld_op, bus.readdata, ld_rt, ld_addr[1:0]);
            state          <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mips_bus_lsu.md
MIPS_BUS_LSU -- requirements
Module: mips_bus_lsu

Interface
REQ-001 Parameter WBUF_DEPTH, default 4, posted-store buffer entries; power of two, >=2.
REQ-002 Parameter ADDR_W, default 32, request/bus address width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 req_valid  in  1  core presents a memory operation.
REQ-006 req_ready  out  1  operation accepted when req_valid && req_ready.
REQ-007 req_op  in  4  lsu_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
REQ-008 req_addr  in  ADDR_W  byte address.
REQ-009 req_rt  in  32  rt value: store data, or merge source for LWL/LWR.
REQ-010 resp_valid  out  1  single-cycle completion pulse, no back-pressure.
REQ-011 resp_data  out  32  load result, zero for stores and faults.
REQ-012 resp_fault  out  1  misaligned access flagged with resp_valid.
REQ-013 address, write, read, writedata[31:0], byteenable[3:0]  out  Avalon-MM master signals.
REQ-014 waitrequest  in  1; readdata  in  32  Avalon-MM slave responses.
REQ-015 wbuf_count  out  $clog2(WBUF_DEPTH)+1  occupied store-buffer entries.

Function
REQ-016 Bus address SHALL be {addr[ADDR_W-1:2],2'b00}. Byte lane n = addr[1:0], little-endian.
REQ-017 read and write SHALL never be high together. address, byteenable and writedata SHALL hold stable while waitrequest is high.
REQ-018 Misaligned accesses are LH, LHU or SH with addr[0]=1, and LW or SW with addr[1:0]!=0. They SHALL cause no bus cycle, give resp_valid=1 and resp_fault=1 the next cycle, and leave the buffer unchanged.
REQ-019 An aligned store SHALL be accepted when the buffer is not full, and SHALL be pushed as {word address, lane-shifted data, byteenable}.
  - Byteenables: SB gives 1<<n; SH gives 0011 or 1100; SW gives 1111.
  - resp_valid SHALL pulse the cycle after acceptance.
REQ-020 Buffer drain: the head entry SHALL drive write=1. The entry pops on the cycle write=1 && waitrequest=0. The earliest bus write is the cycle after the push.
REQ-021 A push and a pop in the same cycle SHALL leave wbuf_count unchanged. req_ready SHALL be 0 when wbuf_count==WBUF_DEPTH, regardless of a concurrent pop.
REQ-022 Load FSM states: IDLE -> DRAIN -> LREQ -> RESP -> IDLE.
  - DRAIN waits for wbuf_count==0, which preserves load-after-store ordering. It is skipped if the buffer is already empty.
  - LREQ holds read=1 and byteenable=1111 until waitrequest=0, then registers readdata.
  - RESP pulses resp_valid.
REQ-023 req_ready SHALL be 0 from load acceptance until the RESP cycle inclusive.
REQ-024 Zero-wait load latency into an empty buffer is: accept at cycle 0, read at cycle 1, resp_valid at cycle 2.
REQ-025 Load formatting, with w = the registered word:
  - LB/LBU: byte n, sign- or zero-extended.
  - LH/LHU: half n[1], sign- or zero-extended.
  - LW: w.
  - LWL: (w << 8*(3-n)) | (rt & (32'hFFFFFFFF >> 8*(n+1))).
  - LWR: (w >> 8*n) | (rt & ~(32'hFFFFFFFF >> 8*n)).
  - LWL and LWR are never misaligned.
REQ-026 wbuf_count SHALL wrap-free track occupancy. Read and write pointers wrap modulo WBUF_DEPTH.

Reset
REQ-027 While reset=0 at a clock edge, the block SHALL enter IDLE, clear all buffer entries and pointers, and abort any bus cycle. Pending stores are discarded.
REQ-028 Reset values: req_ready=0 during reset and 1 after; resp_valid=0; resp_data=0; resp_fault=0; read=0; write=0; address=0; writedata=0; byteenable=0; wbuf_count=0.

Structure
REQ-029 Package mips_lsu_pkg SHALL hold lsu_op_t encodings, the FSM state enum and the wbuf entry struct.
REQ-030 Sub-module mips_lsu_wbuf SHALL implement the parametrised FIFO: push, pop, full, empty, count.

Verification
REQ-031 SW 0x11223344 @0x100, waitrequest=0 -> write=1 at cycle 1, address 0x100, byteenable 1111, resp_valid at cycle 1.
REQ-032 SB 0xAB @0x103 followed by LBU @0x103, with memory model -> byteenable 1000, writedata 0xAB000000; load waits in DRAIN; resp_data=0x000000AB.
REQ-033 Fill the buffer with waitrequest=1 -> wbuf_count=4 and req_ready=0; release waitrequest -> four writes in FIFO order, then req_ready=1.
REQ-034 LH @0x201 -> no read/write asserted, resp_fault=1 one cycle later, resp_data=0.
REQ-035 LWL @0x301 with rt=0xAABBCCDD and memory word 0x44332211 -> resp_data=0x2211CCDD. LWR @0x301 -> resp_data=0xAA443322.
REQ-036 Assert reset=0 during a held read (waitrequest=1) with two buffered stores -> read=0, wbuf_count=0 next cycle, and no writes issued after release.
